// File: rtl/stall_controller.sv
// stall_controller: pipeline stall sequencer for the no-forwarding MIPS-lite core.
//
// Holds PC and IF/ID and injects NOPs into ID/EX for the number of bubbles requested
// by the RAW-hazard detector. Branch flush and HALT take priority over a stall.
// Stall outputs are Mealy in idle, so a hazard seen in cycle N stalls cycle N.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   hazard       RAW hazard on the instruction in ID
//   count        bubbles requested for that hazard (0 is treated as 1)
//   id_valid     ID holds a real instruction; hazard ignored when low
//   flush        EX redirect, kills the ID instruction
//   halt         HALT has reached WB
//   pc_we        PC write enable
//   ifid_we      IF/ID write enable
//   idex_bubble  load a NOP into ID/EX
//   stall        hazard stall in effect this cycle
//   halted       core frozen by HALT
//   stall_cycles hazard bubble cycles since reset
//
// Build option: define STALL_STATS_EN to build the saturating stall_cycles counter;
// without it stall_cycles is tied to zero.

module stall_controller #(
    parameter int unsigned MAX_STALL   = 2,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard,
    input  logic [1:0]             count,
    input  logic                   id_valid,
    input  logic                   flush,
    input  logic                   halt,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   idex_bubble,
    output logic                   stall,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {StIdle, StStall, StHalted} state_e;

    localparam logic [1:0] MaxEff = 2'(MAX_STALL);

    state_e     state_q, state_d;
    logic [1:0] remain_q, remain_d;
    logic [1:0] eff;

    always_comb begin
        if (count == 2'd0) begin
            eff = 2'd1;
        end else if (count > MaxEff) begin
            eff = MaxEff;
        end else begin
            eff = count;
        end
    end

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        stall       = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (halt) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        halted      = 1'b1;
                        state_d     = StHalted;
                    end else if (flush) begin
                        // Flush overrides any hazard; no bubble count is loaded.
                        idex_bubble = 1'b1;
                    end else if (id_valid && hazard) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        stall       = 1'b1;
                        remain_d    = eff - 2'd1;
                        if (eff != 2'd1) begin
                            state_d = StStall;
                        end
                    end
                end
                StStall: begin
                    if (halt) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        halted      = 1'b1;
                        state_d     = StHalted;
                    end else if (flush) begin
                        idex_bubble = 1'b1;
                        remain_d    = 2'd0;
                        state_d     = StIdle;
                    end else begin
                        // hazard/count are not re-sampled while the stall drains.
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        stall       = 1'b1;
                        remain_d    = remain_q - 2'd1;
                        if (remain_q <= 2'd1) begin
                            remain_d = 2'd0;
                            state_d  = StIdle;
                        end
                    end
                end
                StHalted: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    state_d  = StIdle;
                    remain_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            remain_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles with stall asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = rst ? '0 : stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stall_controller.sv
module tb_stall_controller;

    localparam int NV = 25;

    localparam logic [4:0] NORM = 5'b11000;  // {pc_we, ifid_we, idex_bubble, stall, halted}
    localparam logic [4:0] STL  = 5'b00110;
    localparam logic [4:0] FLS  = 5'b11100;
    localparam logic [4:0] HLT  = 5'b00101;
    localparam logic [4:0] RST  = 5'b00100;

    typedef struct {
        logic        rst;
        logic        hazard;
        logic [1:0]  count;
        logic        id_valid;
        logic        flush;
        logic        halt;
        logic [4:0]  outs;
        int unsigned sc;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  outs;
        int unsigned sc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        hazard;
    logic [1:0]  count;
    logic        id_valid;
    logic        flush;
    logic        halt;
    logic        pc_we;
    logic        ifid_we;
    logic        idex_bubble;
    logic        stall;
    logic        halted;
    logic [31:0] stall_cycles;

    int   n_checks = 0;
    int   n_bad    = 0;
    exp_t exp_q[$];
    vec_t tbl[NV];

    stall_controller #(
        .MAX_STALL  (2),
        .STALL_CNT_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hazard      (hazard),
        .count       (count),
        .id_valid    (id_valid),
        .flush       (flush),
        .halt        (halt),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .idex_bubble (idex_bubble),
        .stall       (stall),
        .halted      (halted),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic hz, input logic [1:0] c,
                                input logic v, input logic fl, input logic ht,
                                input logic [4:0] o, input int unsigned s);
        vec_t t;
        t.rst = r; t.hazard = hz; t.count = c; t.id_valid = v;
        t.flush = fl; t.halt = ht; t.outs = o; t.sc = s;
        return t;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show in that cycle.
    task automatic step(input vec_t v, input string name);
        exp_t e;
        rst = v.rst; hazard = v.hazard; count = v.count;
        id_valid = v.id_valid; flush = v.flush; halt = v.halt;
        e.name = name;
        e.outs = v.outs;
`ifdef STALL_STATS_EN
        e.sc = v.sc;
`else
        e.sc = 0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e = exp_q.pop_front();
            act = {pc_we, ifid_we, idex_bubble, stall, halted};
            n_checks++;
            if (act !== e.outs || stall_cycles !== 32'(e.sc)) begin
                n_bad++;
                $display("FAIL %s: got outs=%b stall_cycles=%0d, want outs=%b stall_cycles=%0d",
                         e.name, act, stall_cycles, e.outs, e.sc);
            end
        end
    end

    initial begin
        //                r  hz cnt v  fl ht  outs  sc
        tbl[0]  = mk(1'b1, 0, 2'd0, 0, 0, 0, RST,  0);
        tbl[1]  = mk(1'b1, 1, 2'd2, 1, 0, 0, RST,  0);
        tbl[2]  = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0);
        tbl[3]  = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0);
        tbl[4]  = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0);
        tbl[5]  = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0);
        tbl[6]  = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0);
        tbl[7]  = mk(1'b0, 1, 2'd2, 1, 0, 0, STL,  0);  // count=2: N
        tbl[8]  = mk(1'b0, 0, 2'd0, 1, 0, 0, STL,  1);  // N+1
        tbl[9]  = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 2);  // N+2 released
        tbl[10] = mk(1'b0, 1, 2'd1, 1, 0, 0, STL,  2);  // count=1
        tbl[11] = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 3);
        tbl[12] = mk(1'b0, 1, 2'd0, 1, 0, 0, STL,  3);  // count=0 -> 1 bubble
        tbl[13] = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 4);
        tbl[14] = mk(1'b0, 1, 2'd3, 1, 0, 0, STL,  4);  // count=3 clamped to 2
        tbl[15] = mk(1'b0, 1, 2'd3, 1, 0, 0, STL,  5);  // hazard ignored in STALL
        tbl[16] = mk(1'b0, 1, 2'd1, 1, 0, 0, STL,  6);  // back-to-back fresh stall
        tbl[17] = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 7);
        tbl[18] = mk(1'b0, 1, 2'd2, 0, 0, 0, NORM, 7);  // id_valid=0 masks hazard
        tbl[19] = mk(1'b0, 1, 2'd2, 1, 1, 0, FLS,  7);  // flush beats hazard
        tbl[20] = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 7);  // no count was loaded
        tbl[21] = mk(1'b0, 1, 2'd2, 1, 0, 0, STL,  7);
        tbl[22] = mk(1'b0, 0, 2'd0, 1, 1, 0, FLS,  8);  // flush at N+1
        tbl[23] = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 8);
        tbl[24] = mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 8);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // HALT at N+1 of a 2-bubble stall, held for 20 cycles, then reset.
        step(mk(1'b0, 1, 2'd2, 1, 0, 0, STL, 8), "halt_stall_n");
        step(mk(1'b0, 0, 2'd0, 1, 0, 1, HLT, 9), "halt_enter");
        for (int i = 0; i < 20; i++) begin
            logic [31:0] b;
            b = 32'(i);
            step(mk(1'b0, b[0], b[1:0], 1, b[1], 0, HLT, 9), $sformatf("halt_hold%0d", i));
        end
        step(mk(1'b1, 0, 2'd0, 1, 0, 0, RST,  0), "halt_rst");
        step(mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0), "halt_exit");

        // HALT in IDLE beats simultaneous flush and hazard.
        step(mk(1'b0, 1, 2'd2, 1, 1, 1, HLT, 0), "halt_idle_prio");
        step(mk(1'b0, 0, 2'd0, 1, 0, 0, HLT, 0), "halt_idle_hold");
        step(mk(1'b1, 0, 2'd0, 1, 0, 0, RST, 0), "halt_idle_rst");

        // Reset in the middle of a stall leaves no residual bubble.
        step(mk(1'b0, 1, 2'd2, 1, 0, 0, STL,  0), "rst_mid_n");
        step(mk(1'b1, 0, 2'd0, 1, 0, 0, RST,  0), "rst_mid_rst");
        step(mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0), "rst_mid_after");
        step(mk(1'b0, 0, 2'd0, 1, 0, 0, NORM, 0), "rst_mid_after2");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
